// File: rtl/eth_fcs_gmii_tx_if.sv
// Byte stream from the checksum stage into the FCS/GMII transmitter, plus the
// GMII transmit pins and status pulses coming back out of it.
//   tx_data/tx_en/pre_flag : frame bytes, frame strobe and preamble marker (upstream -> tx)
//   gmii_txd/gmii_tx_en/gmii_tx_er : GMII transmit pins (tx -> PHY)
//   frame_drop/frame_done  : one-cycle status pulses (tx -> observer)
interface eth_fcs_gmii_tx_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       pre_flag;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       frame_drop;
  logic       frame_done;

  // Upstream side: drives frame bytes, watches the GMII side.
  modport master (
    output tx_data, tx_en, pre_flag,
    input  gmii_txd, gmii_tx_en, gmii_tx_er, frame_drop, frame_done
  );

  // Transmitter side.
  modport slave (
    input  tx_data, tx_en, pre_flag,
    output gmii_txd, gmii_tx_en, gmii_tx_er, frame_drop, frame_done
  );
endinterface

// File: rtl/eth_fcs_gmii_tx.sv
// Final Ethernet transmit stage: forwards frame bytes to GMII with one cycle of
// latency, runs CRC-32 over all non-preamble bytes, appends the 4-byte FCS and
// enforces the inter-frame gap. Frames that start too early are dropped whole.
//   tx_clk : byte clock, rising edge
//   rst    : synchronous, active-high reset
//   bus    : slave side of eth_fcs_gmii_tx_if (input bytes in, GMII + status out)
module eth_fcs_gmii_tx #(
  parameter int unsigned IFG_BYTES = 12,
  parameter logic [31:0] CRC_INIT  = 32'hFFFF_FFFF
) (
  input  logic             tx_clk,
  input  logic             rst,
  eth_fcs_gmii_tx_if.slave bus
);

  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam int unsigned IFG_CNT_W = 8;

  typedef enum logic [2:0] {IDLE, DATA, FCS, IFG, SKIP} state_t;

  state_t               state_q, state_n;
  logic [31:0]          crc_q, crc_n;
  logic [IFG_CNT_W-1:0] ifg_cnt_q, ifg_cnt_n;
  logic [1:0]           fcs_idx_q, fcs_idx_n;
  logic                 pend_q, pend_n;
  logic                 tx_en_d;
  logic                 armed_q;
  logic [7:0]           txd_q, txd_n;
  logic                 en_q, en_n;
  logic                 er_q;
  logic                 drop_q, drop_n;
  logic                 done_q, done_n;

  logic                 rise_c;
  logic [31:0]          crc_inv_c;
  logic [7:0]           fcs_byte_c;

  // Reflected CRC-32, one byte consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // armed_q stays low after reset until tx_en has been seen low, so a frame that
  // was already in flight when reset released is never mistaken for a new start.
  assign rise_c     = bus.tx_en & ~tx_en_d & armed_q;
  assign crc_inv_c  = ~crc_q;
  assign fcs_byte_c = crc_inv_c[{fcs_idx_q, 3'b000} +: 8];

  // Next-state and output decode.
  always_comb begin
    state_n   = state_q;
    crc_n     = crc_q;
    ifg_cnt_n = ifg_cnt_q;
    fcs_idx_n = fcs_idx_q;
    pend_n    = pend_q;
    txd_n     = '0;
    en_n      = 1'b0;
    drop_n    = 1'b0;
    done_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_n = DATA;
          txd_n   = bus.tx_data;
          en_n    = 1'b1;
          crc_n   = bus.pre_flag ? CRC_INIT : crc32_byte(CRC_INIT, bus.tx_data);
        end else if (bus.tx_en) begin
          state_n = SKIP;
        end
      end

      DATA: begin
        en_n = 1'b1;
        if (bus.tx_en) begin
          txd_n = bus.tx_data;
          if (!bus.pre_flag) crc_n = crc32_byte(crc_q, bus.tx_data);
        end else begin
          // First FCS byte goes out right behind the last data byte.
          txd_n     = crc_inv_c[7:0];
          fcs_idx_n = 2'd1;
          state_n   = FCS;
        end
      end

      FCS: begin
        en_n      = 1'b1;
        txd_n     = fcs_byte_c;
        fcs_idx_n = 2'(fcs_idx_q + 2'd1);
        if (fcs_idx_q == 2'd3) begin
          done_n    = 1'b1;
          ifg_cnt_n = '0;
          state_n   = IFG;
        end
        if (rise_c) begin
          drop_n = 1'b1;
          pend_n = 1'b1;
        end
      end

      IFG: begin
        if (rise_c) begin
          drop_n = 1'b1;
          pend_n = 1'b1;
        end
        if (ifg_cnt_q == IFG_CNT_W'(IFG_BYTES - 1)) begin
          pend_n  = 1'b0;
          state_n = ((pend_q | rise_c) & bus.tx_en) ? SKIP : IDLE;
        end else begin
          ifg_cnt_n = IFG_CNT_W'(ifg_cnt_q + 1'b1);
        end
      end

      SKIP: begin
        if (!bus.tx_en) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= CRC_INIT;
      ifg_cnt_q <= '0;
      fcs_idx_q <= '0;
      pend_q    <= 1'b0;
      tx_en_d   <= 1'b0;
      armed_q   <= 1'b0;
      txd_q     <= '0;
      en_q      <= 1'b0;
      er_q      <= 1'b0;
      drop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      crc_q     <= crc_n;
      ifg_cnt_q <= ifg_cnt_n;
      fcs_idx_q <= fcs_idx_n;
      pend_q    <= pend_n;
      tx_en_d   <= bus.tx_en;
      armed_q   <= armed_q | ~bus.tx_en;
      txd_q     <= txd_n;
      en_q      <= en_n;
      er_q      <= 1'b0;
      drop_q    <= drop_n;
      done_q    <= done_n;
    end
  end

  assign bus.gmii_txd   = txd_q;
  assign bus.gmii_tx_en = en_q;
  assign bus.gmii_tx_er = er_q;
  assign bus.frame_drop = drop_q;
  assign bus.frame_done = done_q;

endmodule
